// File: rtl/bcd_sub_serial_if.sv
// Handshake and operand/result bundle for the digit-serial BCD subtractor.
// The master side (datapath controller) drives start and the operands.
// The slave side (the subtractor) returns status and the result.
interface bcd_sub_serial_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  borrow;
  logic                  neg;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, neg
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, neg
  );
endinterface

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor: diff = A - B, one decimal digit per clock,
// least-significant digit first.
//
// Operands are held in shift registers that are consumed from the low end.
// Result digits enter diff from the top, so after DIGITS shifts diff holds
// the packed result in the correct order.
//
// Optional feature macro: BCD_SUB_SIGNMAG_EN
//   When defined, a negative result (A < B) is ten's-complemented in an extra
//   NEG pass. This yields the magnitude with neg=1.
//   When undefined, the NEG state does not exist, neg is tied low, and A < B
//   wraps modulo 10^DIGITS with borrow=1.
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  bcd_sub_serial_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

`ifdef BCD_SUB_SIGNMAG_EN
  typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
`endif

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   idx_q;
  logic            bw_q;
  logic [W-1:0]    a_sh_q;
  logic [W-1:0]    b_sh_q;
  logic [W-1:0]    diff_q;
  logic            borrow_q;
  logic            done_q;
  logic [4:0]      sub_res;
  logic [W-1:0]    sub_shift;
`ifdef BCD_SUB_SIGNMAG_EN
  logic            neg_q;
  logic [4:0]      neg_res;
  logic [W-1:0]    neg_shift;
`endif

  // One BCD digit of x - y - bin.
  // Returns {borrow_out, digit}, using the +10 correction when the raw
  // difference is negative.
  function automatic logic [4:0] digit_sub(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       bin);
    logic [4:0] t;
    t = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
    if (t[4]) digit_sub = {1'b1, t[3:0] + 4'd10};
    else      digit_sub = {1'b0, t[3:0]};
  endfunction

  // Per-digit arithmetic, next-state logic and the shift-in value for diff.
  always_comb begin
    state_d   = state_q;
    sub_res   = digit_sub(a_sh_q[3:0], b_sh_q[3:0], bw_q);
    sub_shift = diff_q >> 4;
    sub_shift[W-1 -: 4] = sub_res[3:0];
`ifdef BCD_SUB_SIGNMAG_EN
    neg_res   = digit_sub(4'd0, diff_q[3:0], bw_q);
    neg_shift = diff_q >> 4;
    neg_shift[W-1 -: 4] = neg_res[3:0];
`endif
    case (state_q)
      IDLE: if (bus.start) state_d = SUB;
      SUB: begin
        if (idx_q == LAST_IDX) begin
`ifdef BCD_SUB_SIGNMAG_EN
          state_d = sub_res[4] ? NEG : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef BCD_SUB_SIGNMAG_EN
      NEG:  if (idx_q == LAST_IDX) state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and datapath.
  // The borrow register is reused as the negation borrow during NEG.
  // done is registered so that it pulses in the cycle after DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      bw_q     <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef BCD_SUB_SIGNMAG_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sh_q   <= bus.a;
            b_sh_q   <= bus.b;
            idx_q    <= '0;
            bw_q     <= 1'b0;
            borrow_q <= 1'b0;
`ifdef BCD_SUB_SIGNMAG_EN
            neg_q    <= 1'b0;
`endif
          end
        end
        SUB: begin
          a_sh_q <= a_sh_q >> 4;
          b_sh_q <= b_sh_q >> 4;
          diff_q <= sub_shift;
          bw_q   <= sub_res[4];
          idx_q  <= idx_q + CW'(1);
          if (idx_q == LAST_IDX) begin
            borrow_q <= sub_res[4];
            idx_q    <= '0;
            bw_q     <= 1'b0;
`ifdef BCD_SUB_SIGNMAG_EN
            if (sub_res[4]) neg_q <= 1'b1;
`endif
          end
        end
`ifdef BCD_SUB_SIGNMAG_EN
        NEG: begin
          diff_q <= neg_shift;
          bw_q   <= neg_res[4];
          idx_q  <= idx_q + CW'(1);
          if (idx_q == LAST_IDX) begin
            idx_q <= '0;
            bw_q  <= 1'b0;
          end
        end
`endif
        DONE: done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef BCD_SUB_SIGNMAG_EN
  assign bus.neg    = neg_q;
`else
  assign bus.neg    = 1'b0;
`endif

endmodule

// File: doc/bcd_sub_serial.md
# bcd_sub_serial

Digit-serial, multi-digit BCD subtractor. It computes A − B on packed BCD operands and processes one decimal digit per clock, least-significant digit first, using the same per-digit borrow/carry discipline as the team's single-digit BCD full adder. It sits beside the BCD adder chain as the inverse arithmetic path and is driven by a start/done handshake from the datapath controller.

## Interface
- DIGITS, default 4 — number of BCD digits per operand (≥1).
- clk  in  1  — rising-edge clock.
- rst  in  1  — synchronous reset, active-high.
- start  in  1  — request; sampled on a clk edge only while idle.
- a  in  4*DIGITS  — minuend; packed BCD, digit 0 in a[3:0].
- b  in  4*DIGITS  — subtrahend; same packing as a.
- busy  out  1  — high while an operation is in progress.
- done  out  1  — one-cycle pulse when diff, borrow and neg are valid.
- diff  out  4*DIGITS  — packed BCD result.
- borrow  out  1  — final borrow out of the most-significant digit (1 ⇔ A < B).
- neg  out  1  — result is negative in sign-magnitude form. Tied 0 unless the macro below is defined.

## Operation
- States: IDLE, SUB, NEG (only with the macro), DONE.
- IDLE: when start=1, latch a and b, clear the digit index and internal borrow bw, then go to SUB. busy=0.
- SUB: process one digit i per cycle.
  - Compute t = a_i − b_i − bw using signed 5-bit arithmetic.
  - If t < 0: diff_i = t + 10 and bw = 1; otherwise diff_i = t and bw = 0.
  - After digit DIGITS−1: borrow = bw.
  - If the macro is enabled and bw = 1, go to NEG; otherwise go to DONE.
- NEG: ten's-complement the stored diff digit-serially.
  - Compute d_i = 0 − diff_i − nb, with the same +10 correction; nb starts at 0.
  - neg = 1.
  - After DIGITS cycles, go to DONE.
- DONE: done = 1 for one cycle, busy = 0, then go to IDLE.
- Output holding:
  - diff, borrow and neg hold their values from done until the next accepted start.
  - On an accepted start, borrow and neg clear and diff becomes don't-care until done.
- start while busy=1 or in DONE: ignored, with no queuing.
- Operands are latched, so a and b may change after start is accepted.
- Inputs must be valid BCD digits 0–9. Results for non-BCD inputs are unspecified, and the bench does not drive them.
- Wrap-around: without the macro, A < B yields the ten's complement modulo 10^DIGITS with borrow = 1.

## Timing
- Reset values: busy=0, done=0, diff=0, borrow=0, neg=0. State = IDLE.
- rst asserted in any state (including mid-SUB or mid-NEG): all outputs return to their reset values on that edge, and no done is generated.
- Take start sampled at edge k:
  - busy is high from after edge k.
  - done is high in the cycle after edge k+DIGITS+1, or after edge k+2·DIGITS+1 when NEG runs.
- Latency from start to done: DIGITS+1 cycles, or 2·DIGITS+1 cycles with negation.
- Throughput: a new start is accepted in the cycle after done, at the earliest.
- rst and start high on the same edge: rst wins.

## Configuration
- BCD_SUB_SIGNMAG_EN
  - Defined: A < B produces the magnitude |A−B| in diff with neg=1 and borrow=1, via the extra NEG phase of DIGITS cycles.
  - Undefined: the NEG state is not built, neg is tied to 0, and the result is the ten's-complement wrap with borrow=1.

## Test plan
All scenarios use DIGITS = 4.
- a=0x5432, b=0x1234, start at edge 0 → done at edge 5; diff=0x4198, borrow=0, neg=0.
- a=0x1000, b=0x0001 → borrow ripples through three digits; diff=0x0999, borrow=0.
- a=0x0000, b=0x0001:
  - Without the macro → diff=0x9999, borrow=1, neg=0, done after 5 cycles.
  - With the macro → diff=0x0001, borrow=1, neg=1, done after 9 cycles.
- a=0x9999, b=0x9999 → diff=0x0000, borrow=0. A second start pulsed during SUB is ignored: exactly one done, and busy stays high for 5 cycles.
- Start a=0x5000, b=0x0001, then assert rst at cycle 2 → busy, done, diff, borrow and neg are 0 the next cycle with no done pulse. A following start with a=0x0042, b=0x0017 gives diff=0x0025.
